// File: rtl/mppt_pkg.sv
// mppt_pkg: shared channel map, ADC width and scan FSM encoding for the MPPT sense path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: NUM_CH, ADC_W, CH_* channel indices, scan_state_e, next_enabled().
package mppt_pkg;

  localparam int NUM_CH = 6;
  localparam int ADC_W  = 12;

  localparam int CH_BATT_V  = 0;
  localparam int CH_BATT_I  = 1;
  localparam int CH_SOLAR_V = 2;
  localparam int CH_SOLAR_I = 3;
  localparam int CH_TEMP1   = 4;
  localparam int CH_TEMP2   = 5;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    START,
    WAIT,
    STORE,
    PUBLISH
  } scan_state_e;

  // Lowest enabled channel index >= from. Bit 3 is the found flag, bits 2:0 the index.
  // Scanning downwards lets the lowest match overwrite higher ones.
  function automatic logic [3:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                              input logic [2:0]        from);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: period counter producing a one-cycle tick on the wrap cycle.
// Latency: tick_o is combinational, high while count == PERIOD-1 and enable_i is set.
// Backpressure: none; counter is held at zero and no ticks are produced while enable_i is low.
// Ports: clk_i, rst_i (sync, active-high), enable_i, tick_o.
module scan_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i & wrap;

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic, averaged scan of six sense channels on one shared SAR ADC.
// Latency: tick -> first adc_start in 2 cycles; an all-masked scan pulses scan_done 2 cycles after tick.
// Backpressure: none; ticks while busy are dropped (overrun), a silent ADC is aborted after TIMEOUT_CYC.
// Ports: clk, rst (sync, active-high), enable, ch_mask, err_clr | adc_start, adc_ch, adc_done,
//        adc_data | result (6 x 12b, ch i at [12i+11:12i]), scan_done, busy, err_ch, overrun.
module adc_scan_sequencer
  import mppt_pkg::*;
#(
  parameter int SCAN_PERIOD = 1000,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic                    err_clr,
  output logic                    adc_start,
  output logic [2:0]              adc_ch,
  input  logic                    adc_done,
  input  logic [ADC_W-1:0]        adc_data,
  output logic [NUM_CH*ADC_W-1:0] result,
  output logic                    scan_done,
  output logic                    busy,
  output logic [NUM_CH-1:0]       err_ch,
  output logic                    overrun
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  scan_state_e              state_q, state_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [2:0]               idx_q, idx_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         smp_q, smp_d;
  logic [TO_W-1:0]          to_q, to_d;
  logic [NUM_CH*ADC_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH*ADC_W-1:0]  result_q, result_d;
  logic [NUM_CH-1:0]        err_q, err_d, err_set;
  logic                     ovr_q, ovr_d, ovr_set;
  logic                     tick;
  logic [3:0]               nxt;

  scan_timer #(
    .PERIOD (SCAN_PERIOD)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    to_d      = to_q;
    shadow_d  = shadow_q;
    result_d  = result_q;
    err_set   = '0;
    adc_start = 1'b0;
    nxt       = next_enabled(mask_q, idx_q);

    case (state_q)
      IDLE: begin
        if (tick) begin
          mask_d  = ch_mask;
          idx_d   = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        if (nxt[3]) begin
          idx_d   = nxt[2:0];
          acc_d   = '0;
          smp_d   = '0;
          state_d = START;
        end else begin
          // Load the published copy on entry to PUBLISH so result and scan_done line up.
          result_d = shadow_q;
          state_d  = PUBLISH;
        end
      end
      START: begin
        adc_start = 1'b1;
        to_d      = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // done wins over a timeout expiring in the same cycle
        if (adc_done) begin
          acc_d = acc_q + ACC_W'(adc_data);
          smp_d = smp_q + CNT_W'(1);
          if (smp_q == CNT_W'(NSAMP - 1)) begin
            state_d = STORE;
          end else begin
            state_d = START;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_set[idx_q] = 1'b1;
          idx_d          = idx_q + 3'd1;
          state_d        = SEL;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      STORE: begin
        shadow_d[int'(idx_q)*ADC_W +: ADC_W] = ADC_W'(acc_q >> AVG_LOG2);
        idx_d   = idx_q + 3'd1;
        state_d = SEL;
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ovr_set = tick & (state_q != IDLE);

    // clear beats a same-cycle set
    if (err_clr) begin
      err_d = '0;
      ovr_d = 1'b0;
    end else begin
      err_d = err_q | err_set;
      ovr_d = ovr_q | ovr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      to_q     <= '0;
      shadow_q <= '0;
      result_q <= '0;
      err_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      to_q     <= to_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign adc_ch    = idx_q;
  assign result    = result_q;
  assign scan_done = (state_q == PUBLISH);
  assign busy      = (state_q != IDLE);
  assign err_ch    = err_q;
  assign overrun   = ovr_q;

endmodule
